// File: rtl/load_store_unit.sv
// Data-memory access stage: valid/grant/rvalid bus master with PC stall and load extension.
// Optional build macro LSU_MISALIGN_TRAP_EN turns misaligned accesses into errors instead of aligning them.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ls_valid,
  input  logic        ls_store,
  input  logic [2:0]  ls_funct3,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_stall,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  output logic        ls_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       funct3_q;
  logic [1:0]       off_q;

  logic             legal_c;
  logic             reject_c;
  logic [1:0]       off_c;
  logic [3:0]       be_c;
  logic [31:0]      wdata_c;

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      3'b000:  load_extend = {{24{sh[7]}}, sh[7:0]};
      3'b001:  load_extend = {{16{sh[15]}}, sh[15:0]};
      3'b100:  load_extend = {24'h0, sh[7:0]};
      3'b101:  load_extend = {16'h0, sh[15:0]};
      default: load_extend = word;
    endcase
  endfunction

  // Decode the incoming request: legality, lane offset, byte enables, replicated store data
  always_comb begin
    legal_c = ls_store ? (ls_funct3 inside {3'b000, 3'b001, 3'b010})
                       : (ls_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    reject_c = !legal_c;
    off_c    = ls_addr[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
    if ((ls_funct3[1:0] == 2'b01 && ls_addr[0]) ||
        (ls_funct3[1:0] == 2'b10 && ls_addr[1:0] != 2'b00))
      reject_c = 1'b1;
`else
    if (ls_funct3[1:0] == 2'b01)
      off_c[0] = 1'b0;
    else if (ls_funct3[1:0] == 2'b10)
      off_c = 2'b00;
`endif
    be_c    = 4'b1111;
    wdata_c = '0;
    if (ls_store) begin
      case (ls_funct3[1:0])
        2'b00: begin
          be_c    = 4'b0001 << off_c;
          wdata_c = {4{ls_wdata[7:0]}};
        end
        2'b01: begin
          be_c    = off_c[1] ? 4'b1100 : 4'b0011;
          wdata_c = {2{ls_wdata[15:0]}};
        end
        default: begin
          be_c    = 4'b1111;
          wdata_c = ls_wdata;
        end
      endcase
    end
  end

  assign ls_stall = (state == S_IDLE && ls_valid) || state == S_REQ || state == S_WAIT_R;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      funct3_q  <= '0;
      off_q     <= '0;
      ls_done   <= 1'b0;
      ls_rdata  <= '0;
      ls_err    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      ls_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ls_valid) begin
            funct3_q <= ls_funct3;
            off_q    <= off_c;
            cnt      <= '0;
            ls_rdata <= '0;
            if (reject_c) begin
              ls_err  <= 1'b1;
              ls_done <= 1'b1;
              state   <= S_DONE;
            end else begin
              ls_err    <= 1'b0;
              mem_req   <= 1'b1;
              mem_we    <= ls_store;
              mem_be    <= be_c;
              mem_addr  <= {ls_addr[31:2], 2'b00};
              mem_wdata <= wdata_c;
              state     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          cnt <= cnt + CNT_W'(1);
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (mem_we) begin
              ls_done <= 1'b1;
              state   <= S_DONE;
            end else begin
              state <= S_WAIT_R;
            end
          end else if (cnt == CNT_LAST) begin
            mem_req <= 1'b0;
            ls_err  <= 1'b1;
            ls_done <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_WAIT_R: begin
          cnt <= cnt + CNT_W'(1);
          if (mem_rvalid) begin
            ls_rdata <= load_extend(funct3_q, off_q, mem_rdata);
            ls_done  <= 1'b1;
            state    <= S_DONE;
          end else if (cnt == CNT_LAST) begin
            ls_err  <= 1'b1;
            ls_done <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed cases plus randomized accesses vs. a behavioural model.
`timescale 1ns/1ps
module tb_load_store_unit;

  localparam int unsigned T = 8;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    bit          is_load;
  } exp_t;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        ls_valid, ls_store;
  logic [2:0]  ls_funct3;
  logic [31:0] ls_addr, ls_wdata;
  logic        ls_stall, ls_done, ls_err;
  logic [31:0] ls_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int          n_cmp = 0;
  int          n_fail = 0;
  exp_t        exp_q[$];
  bus_t        bus_q[$];

  int          gnt_dly = 0;
  int          rv_dly = 0;
  bit          never_gnt = 1'b0;
  logic [31:0] cur_rword = '0;

  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .ls_valid(ls_valid), .ls_store(ls_store), .ls_funct3(ls_funct3),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_stall(ls_stall), .ls_done(ls_done), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: what the access should do, from RV32I size/sign rules and lane arithmetic
  function automatic void model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rw,
                                output bit rej, output bus_t b, output logic [31:0] rd);
    int size, off;
    bit legal;
    longint unsigned v;
    legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size  = 1 << int'(f3[1:0]);
    rej   = !legal;
    off   = int'(a[1:0]);
`ifdef LSU_MISALIGN_TRAP_EN
    if (legal && (off % size) != 0) rej = 1'b1;
`endif
    off     = off - (off % size);
    b.we    = st;
    b.addr  = a & 32'hFFFF_FFFC;
    b.wdata = '0;
    b.be    = 4'hF;
    rd      = '0;
    if (st) begin
      b.be = 4'(((1 << size) - 1) << off);
      for (int i = 0; i < 4; i++) b.wdata[8*i +: 8] = wd[8*(i % size) +: 8];
    end else begin
      v = (64'(rw) >> (8 * off)) & ((64'd1 << (8 * size)) - 64'd1);
      if (!f3[2] && size < 4 && v >= (64'd1 << (8 * size - 1)))
        v = v + 64'h1_0000_0000 - (64'd1 << (8 * size));
      rd = 32'(v);
    end
  endfunction

  // Memory responder: grants after gnt_dly cycles, returns read data rv_dly cycles after grant
  initial begin
    logic we_l;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req && !never_gnt) begin
        repeat (gnt_dly) @(negedge clk);
        mem_gnt = 1'b1;
        we_l = mem_we;
        @(negedge clk);
        mem_gnt = 1'b0;
        if (!we_l) begin
          repeat (rv_dly) @(negedge clk);
          mem_rvalid = 1'b1;
          mem_rdata  = cur_rword;
          @(negedge clk);
          mem_rvalid = 1'b0;
          mem_rdata  = $urandom;
        end
      end
    end
  end

  // Monitor: pop and compare on every completion and every accepted bus request
  initial begin
    exp_t e;
    bus_t b;
    forever begin
      @(negedge clk);
      #1;
      if (ls_done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 32'(ls_done), 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("ls_err", 32'(ls_err), 32'(e.err));
          if (e.is_load) chk("ls_rdata", ls_rdata, e.rd);
        end
      end
      if (mem_req && mem_gnt) begin
        if (bus_q.size() == 0) chk("unexpected_gnt", 32'(mem_req), 32'd0);
        else begin
          b = bus_q.pop_front();
          chk("mem_we", 32'(mem_we), 32'(b.we));
          chk("mem_be", 32'(mem_be), 32'(b.be));
          chk("mem_addr", mem_addr, b.addr);
          if (b.we) chk("mem_wdata", mem_wdata, b.wdata);
        end
      end
    end
  end

  task automatic do_access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rw,
                           input int g, input int r, input bit nog);
    bit rej, got;
    bus_t b;
    logic [31:0] rd;
    int exp_lat, exp_req, cyc, req_cnt, stall_bad;
    exp_t e;
    model(st, f3, a, wd, rw, rej, b, rd);
    e.is_load = !st;
    if (rej) begin
      exp_lat = 1; exp_req = 0; e.err = 1'b1; e.rd = '0;
    end else if (nog) begin
      exp_lat = T + 1; exp_req = T; e.err = 1'b1; e.rd = '0;
    end else begin
      bus_q.push_back(b);
      exp_req = g + 1;
      exp_lat = st ? 2 + g : 3 + g + r;
      e.err = 1'b0; e.rd = rd;
    end
    exp_q.push_back(e);
    gnt_dly = g; rv_dly = r; never_gnt = nog; cur_rword = rw;
    ls_store = st; ls_funct3 = f3; ls_addr = a; ls_wdata = wd; ls_valid = 1'b1;
    #1 chk("stall_on_valid", 32'(ls_stall), 32'd1);
    cyc = 0; req_cnt = 0; stall_bad = 0; got = 1'b0;
    while (!got && cyc < 64) begin
      @(negedge clk);
      cyc++;
      if (mem_req) req_cnt++;
      if (ls_done) got = 1'b1;
      else if (!ls_stall) stall_bad++;
    end
    chk("done_latency", 32'(cyc), 32'(exp_lat));
    chk("req_cycles", 32'(req_cnt), 32'(exp_req));
    chk("stall_held", 32'(stall_bad), 32'd0);
    chk("stall_in_done", 32'(ls_stall), 32'd0);
    ls_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bit rej;
    bus_t b;
    logic [31:0] rd;
    reset = 1'b1; ls_valid = 1'b0; ls_store = 1'b0; ls_funct3 = '0; ls_addr = '0; ls_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_done", 32'(ls_done), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_err", 32'(ls_err), 32'd0);
    chk("rst_rdata", ls_rdata, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_stall_idle", 32'(ls_stall), 32'd0);
    ls_valid = 1'b1;
    #1 chk("rst_stall_valid", 32'(ls_stall), 32'd1);
    ls_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    do_access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 1'b0);
    do_access(1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0, 0, 1'b0);
    do_access(1'b0, 3'b000, 32'h103, 32'h0, 32'hA5000000, 0, 0, 1'b0);
    do_access(1'b0, 3'b100, 32'h103, 32'h0, 32'hA5000000, 1, 0, 1'b0);
    do_access(1'b0, 3'b001, 32'h102, 32'h0, 32'h80010000, 3, 2, 1'b0);
    do_access(1'b0, 3'b010, 32'h101, 32'h0, 32'h12345678, 0, 0, 1'b0);
    do_access(1'b1, 3'b001, 32'h203, 32'h0000BEEF, 32'h0, 1, 0, 1'b0);
    do_access(1'b0, 3'b010, 32'h200, 32'h0, 32'h0, 0, 0, 1'b1);
    do_access(1'b1, 3'b010, 32'h204, 32'h11223344, 32'h0, 0, 0, 1'b1);
    do_access(1'b0, 3'b011, 32'h200, 32'h0, 32'hFFFFFFFF, 0, 0, 1'b0);
    do_access(1'b1, 3'b100, 32'h200, 32'h1, 32'h0, 0, 0, 1'b0);

    // Reset while waiting for read data; the late rvalid must be ignored
    gnt_dly = 0; rv_dly = 4; never_gnt = 1'b0; cur_rword = 32'h5555AAAA;
    model(1'b0, 3'b010, 32'h300, 32'h0, cur_rword, rej, b, rd);
    bus_q.push_back(b);
    ls_store = 1'b0; ls_funct3 = 3'b010; ls_addr = 32'h300; ls_valid = 1'b1;
    @(negedge clk);
    ls_valid = 1'b0;
    @(negedge clk);
    chk("wait_r_stall", 32'(ls_stall), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_req", 32'(mem_req), 32'd0);
    chk("midrst_stall", 32'(ls_stall), 32'd0);
    chk("midrst_rdata", ls_rdata, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("late_rvalid_ignored", {30'd0, ls_done, mem_req}, 32'd0);
    end
    do_access(1'b0, 3'b010, 32'h304, 32'h0, 32'hCAFEF00D, 0, 0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      do_access(1'($urandom_range(1)), 3'($urandom_range(7)),
                32'h1000 + 32'($urandom_range(4095)), $urandom, $urandom,
                $urandom_range(2), $urandom_range(3), ($urandom_range(15) == 0));
    end

    repeat (4) @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
